// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU control codes, datapath widths, sequencer state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_BR_W   = 24;
  localparam int CTL_W      = 11;

  localparam logic [CTL_W-1:0] BRANCH      = 11'd31;
  localparam logic [CTL_W-1:0] BRANCH_LINK = 11'd32;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_ISSUE,
    ST_LINK,
    ST_HALT
  } seq_state_t;

  function automatic logic is_branch(input logic [CTL_W-1:0] ctl);
    return (ctl == BRANCH) || (ctl == BRANCH_LINK);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC and return-address arithmetic for the sequencer.
// Latency: purely combinational. Backpressure: none.
// Branch offsets are zero-extended word offsets; all sums wrap modulo 2^ADDR_W.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int BR_W   = CPU_BR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [CTL_W-1:0]  alu_ctl,
  input  logic [BR_W-1:0]   br_offset,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] link_value
);

  logic [ADDR_W-1:0] off_ext;

  assign off_ext    = ADDR_W'(br_offset);
  assign link_value = pc + ADDR_W'(1);
  assign next_pc    = is_branch(alu_ctl) ? (pc + off_ext) : link_value;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer owning the architectural PC, link writeback and retired count.
// Latency: 2 cycles per instruction (FETCH, ISSUE), 3 for branch-with-link.
// Backpressure: imem_req/link_we held until acked; ISSUE waits for ctl_valid & !stall.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                BR_W     = CPU_BR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dec_valid,
  output logic [31:0]       instr_out,
  input  logic              ctl_valid,
  input  logic [CTL_W-1:0]  alu_ctl,
  input  logic [BR_W-1:0]   br_offset,
  input  logic              stall,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  input  logic              link_ack,
  input  logic              halt_req,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       retired
);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              instr_ld;
  logic              advance;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] link_value;

  pc_next_calc #(
    .ADDR_W(ADDR_W),
    .BR_W  (BR_W)
  ) u_next (
    .pc        (pc),
    .alu_ctl   (alu_ctl),
    .br_offset (br_offset),
    .next_pc   (next_pc),
    .link_value(link_value)
  );

  // Handshake outputs are pure state decodes, so reset drops them immediately.
  assign imem_req  = (state == ST_FETCH);
  assign dec_valid = (state == ST_ISSUE);
  assign link_we   = (state == ST_LINK);
  assign halted    = (state == ST_HALT);
  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    instr_ld  = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_ld  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ctl_valid && !stall) begin
          advance = 1'b1;
          if (alu_ctl == BRANCH_LINK) state_nxt = ST_LINK;
          else if (halt_req)          state_nxt = ST_HALT;
          else                        state_nxt = ST_FETCH;
        end
      end
      ST_LINK: begin
        if (link_ack) state_nxt = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      instr_out <= '0;
      link_data <= '0;
      retired   <= '0;
    end else begin
      state <= state_nxt;
      if (instr_ld) instr_out <= imem_rdata;
      if (advance) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
        if (alu_ctl == BRANCH_LINK) link_data <= link_value;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: driver pushes expected fetch/link events,
// a monitor pops them whenever the DUT raises imem_req or link_we.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dec_valid;
  logic [31:0] instr_out;
  logic        ctl_valid = 1'b0;
  logic [10:0] alu_ctl = '0;
  logic [23:0] br_offset = '0;
  logic        stall = 1'b0;
  logic        link_we;
  logic [31:0] link_data;
  logic        link_ack = 1'b0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic [31:0] pc;
  logic [31:0] retired;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ret;
  } fetch_exp_t;

  fetch_exp_t  exp_fetch[$];
  logic [31:0] exp_link[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          link_rises = 0;
  bit          aborted = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_ret = '0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .dec_valid (dec_valid),
    .instr_out (instr_out),
    .ctl_valid (ctl_valid),
    .alu_ctl   (alu_ctl),
    .br_offset (br_offset),
    .stall     (stall),
    .link_we   (link_we),
    .link_data (link_data),
    .link_ack  (link_ack),
    .halt_req  (halt_req),
    .halted    (halted),
    .pc        (pc),
    .retired   (retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] addr, input logic [31:0] ret);
    fetch_exp_t fe;
    fe.addr = addr;
    fe.ret  = ret;
    exp_fetch.push_back(fe);
  endtask

  // Monitor: every rising imem_req / link_we is matched against the scoreboard.
  initial begin
    logic       prev_req;
    logic       prev_lw;
    fetch_exp_t e;
    logic [31:0] el;
    prev_req = 1'b0;
    prev_lw  = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req && !prev_req) begin
        if (exp_fetch.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_fetch: got fetch at 0x%0h, expected no fetch", imem_addr);
        end else begin
          e = exp_fetch.pop_front();
          check("fetch_addr", imem_addr, e.addr);
          check("retired_at_fetch", retired, e.ret);
        end
      end
      if (link_we && !prev_lw) begin
        link_rises++;
        if (exp_link.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_link: got link_data 0x%0h, expected no link write", link_data);
        end else begin
          el = exp_link.pop_front();
          check("link_data", link_data, el);
        end
      end
      prev_req = imem_req;
      prev_lw  = link_we;
    end
  end

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    aborted = 1'b1;
    $finish;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      n_vec++;
      n_err++;
      $display("FAIL fetch_timeout: got imem_req=0 after %0d cycles, expected 1", n);
      finish_now();
    end
  endtask

  // Starts between edges; returns at a negedge with the DUT in FETCH at RESET_PC.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_link_we", link_we, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_link_data", link_data, 0);
    check("rst_retired", retired, 0);
    exp_fetch.delete();
    exp_link.delete();
    m_pc  = '0;
    m_ret = '0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    ctl_valid  = 1'b0;
    stall      = 1'b0;
    link_ack   = 1'b1;
    halt_req   = 1'b1;
    @(negedge clk);
    push_fetch(32'd0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    link_ack = 1'b0;
    halt_req = 1'b0;
    check("boot_imem_req", imem_req, 1);
    check("boot_late_ack_ignored", instr_out, 0);
  endtask

  task automatic do_instr(input logic [10:0] alu, input logic [23:0] off, input int nstall,
                          input int ack_dly, input int link_dly, input bit halt, input bit rst_in_link);
    logic [31:0] rd;
    logic [31:0] npc;
    bit          bl;
    bit          br;
    wait_req();
    if (aborted) return;
    check("pc_at_fetch", pc, m_pc);
    for (int i = 0; i < ack_dly; i++) begin
      ctl_valid = 1'($urandom);
      link_ack  = 1'($urandom);
      halt_req  = 1'($urandom);
      @(negedge clk);
      check("imem_req_held", imem_req, 1);
    end
    rd = $urandom;
    imem_ack = 1'b1;
    imem_rdata = rd;
    ctl_valid = 1'b0;
    link_ack = 1'b0;
    halt_req = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    check("dec_valid", dec_valid, 1);
    check("instr_out", instr_out, rd);

    bl  = (alu == 11'd32);
    br  = (alu == 11'd31) || bl;
    npc = br ? (m_pc + {8'd0, off}) : (m_pc + 32'd1);
    alu_ctl = alu;
    br_offset = off;
    ctl_valid = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < nstall; i++) begin
      imem_ack = 1'($urandom);
      link_ack = 1'($urandom);
      halt_req = 1'($urandom);
      @(negedge clk);
      check("stall_pc", pc, m_pc);
      check("stall_dec_valid", dec_valid, 1);
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    link_ack = 1'b0;
    halt_req = halt;
    m_ret = m_ret + 32'd1;
    if (bl) exp_link.push_back(m_pc + 32'd1);
    m_pc = npc;
    if (!bl && !halt) push_fetch(m_pc, m_ret);
    @(negedge clk);
    ctl_valid = 1'b0;
    halt_req = 1'b0;
    alu_ctl = 11'($urandom);
    br_offset = 24'($urandom);
    check("pc_after_issue", pc, m_pc);
    check("retired_after_issue", retired, m_ret);

    if (bl) begin
      check("link_we_on", link_we, 1);
      if (rst_in_link) begin
        apply_reset();
        return;
      end
      for (int i = 0; i < link_dly; i++) begin
        ctl_valid = 1'($urandom);
        halt_req  = 1'($urandom);
        imem_ack  = 1'($urandom);
        @(negedge clk);
        check("link_we_held", link_we, 1);
      end
      ctl_valid = 1'b0;
      imem_ack = 1'b0;
      halt_req = halt;
      link_ack = 1'b1;
      if (!halt) push_fetch(m_pc, m_ret);
      @(negedge clk);
      link_ack = 1'b0;
      halt_req = 1'b0;
      check("link_we_off", link_we, 0);
    end

    if (halt) begin
      check("halted", halted, 1);
      check("halt_no_req", imem_req, 0);
    end else begin
      check("refetch_latency", imem_req, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, expected finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lr;
    int r;
    logic [10:0] a;
    apply_reset();

    // Straight-line stream, zero wait states.
    for (int i = 0; i < 4; i++) do_instr(11'd0, 24'($urandom), 0, 0, 0, 0, 0);
    check("seq_retired", retired, 4);
    check("seq_pc", imem_addr, 4);

    // Plain branches: 4 -> 234 -> 734, never touching the link port.
    lr = link_rises;
    do_instr(11'd31, 24'd230, 0, 0, 0, 0, 0);
    do_instr(11'd31, 24'd500, 0, 1, 0, 0, 0);
    check("branch_no_link", link_rises, lr);

    // Reset mid-fetch, then branch-with-link from 675 with a slow register file.
    apply_reset();
    do_instr(11'd31, 24'd675, 0, 0, 0, 0, 0);
    do_instr(11'd32, 24'd600, 0, 0, 3, 0, 0);
    check("bl_target", pc, 32'd1275);

    // Walk the PC to 0xFFFFFFFF with maximal offsets, then wrap.
    apply_reset();
    for (int i = 0; i < 256; i++) do_instr(11'd31, 24'hFF_FFFF, 0, 0, 0, 0, 0);
    do_instr(11'd31, 24'h0000FF, 0, 0, 0, 0, 0);
    check("pc_all_ones", pc, 32'hFFFF_FFFF);
    do_instr(11'd0, 24'd7, 0, 0, 0, 0, 0);
    check("pc_wrap", pc, 32'd0);

    // Reset while the link write is pending.
    do_instr(11'd32, 24'($urandom), 0, 0, 2, 0, 1);

    for (int n = 0; n < 150 && !aborted; n++) begin
      r = $urandom_range(0, 3);
      a = (r == 0) ? 11'd31 : (r == 1) ? 11'd32 : 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 19) == 0) begin
        do_instr(a, 24'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 3), 1, 0);
        apply_reset();
      end else begin
        do_instr(a, 24'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 3), 0, 0);
      end
    end

    // Long stall with ctl_valid present, then halt.
    do_instr(11'd5, 24'd9, 5, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'($urandom);
      ctl_valid = 1'($urandom);
      link_ack = 1'($urandom);
      @(negedge clk);
      check("halt_parked", halted, 1);
      check("halt_req_low", imem_req, 0);
      check("halt_pc", pc, m_pc);
    end
    check("scoreboard_fetch_drained", exp_fetch.size(), 0);
    check("scoreboard_link_drained", exp_link.size(), 0);
    if (!aborted) begin
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

endmodule
